// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter sharing one APB3/APB4 master port
// between NUM_REQ requesters, with PREADY wait states and an access timeout.
module apb_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
    input  logic [NUM_REQ*3-1:0]        req_prot,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [ADDR_W-1:0]           PADDR,
    output logic [DATA_W-1:0]           PWDATA,
    output logic [DATA_W/8-1:0]         PSTRB,
    output logic [2:0]                  PPROT,
    input  logic                        PREADY,
    input  logic                        PSLVERR,
    input  logic [DATA_W-1:0]           PRDATA
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  owner;
    logic              any_valid;
    int                idx;

    logic              grant;
    logic              done;
    logic              abort;
    logic              timeout_hit;
    logic [CNT_W-1:0]  wait_cnt;

    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic [2:0]        cmd_prot;

    // Search starts just after the last winner; the smallest offset wins.
    always_comb begin
        winner    = last_grant;
        any_valid = |req_valid;
        idx       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                winner = IDX_W'(idx);
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LAST_WAIT);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        req_ready  = '0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        PWRITE     = 1'b0;
        PADDR      = '0;
        PWDATA     = '0;
        PSTRB      = '0;
        PPROT      = '0;
        unique case (state)
            IDLE: begin
                if (any_valid && !PRESET) begin
                    grant      = 1'b1;
                    req_ready  = NUM_REQ'(1) << winner;
                    state_next = SETUP;
                end
            end
            SETUP, ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (state == ACCESS);
                PWRITE  = cmd_write;
                PADDR   = cmd_addr;
                PPROT   = cmd_prot;
                // Reads never present data or strobes on the bus.
                PWDATA  = cmd_write ? cmd_wdata : '0;
                PSTRB   = cmd_write ? cmd_strb : '0;
                if (state == SETUP) begin
                    state_next = ACCESS;
                end else if (PREADY) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            last_grant <= LAST_IDX;
            owner      <= '0;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_strb   <= '0;
            cmd_prot   <= '0;
            wait_cnt   <= '0;
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            if (grant) begin
                owner      <= winner;
                last_grant <= winner;
                cmd_write  <= req_write[winner];
                cmd_addr   <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
                cmd_wdata  <= req_wdata[int'(winner)*DATA_W +: DATA_W];
                cmd_strb   <= req_strb[int'(winner)*STRB_W +: STRB_W];
                cmd_prot   <= req_prot[int'(winner)*3 +: 3];
            end
            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && !PREADY && !timeout_hit) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (done || abort) begin
                rsp_valid <= NUM_REQ'(1) << owner;
                rsp_err   <= abort | PSLVERR;
                rsp_rdata <= (done && !PSLVERR && !cmd_write) ? PRDATA : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: randomized bench for apb_master_arbiter against a
// behavioural round-robin and APB completer reference model.
`timescale 1ns/1ps
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_strb;
    logic [N*3-1:0]  req_prot;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [SW-1:0]   PSTRB;
    logic [2:0]      PPROT;
    logic            PREADY;
    logic            PSLVERR;
    logic [DW-1:0]   PRDATA;

    int checks   = 0;
    int failures = 0;

    int            cfg_waits = 0;
    logic          cfg_err   = 1'b0;
    logic [DW-1:0] cfg_rdata = '0;
    int            acc_cnt   = 0;
    int            model_last = N - 1;

    logic          m_w [N];
    logic [AW-1:0] m_a [N];
    logic [DW-1:0] m_d [N];
    logic [SW-1:0] m_s [N];
    logic [2:0]    m_p [N];

    typedef struct {
        logic [N-1:0]  gnt;
        bit            gnt_psel;
        int            setup;
        int            access;
        int            total;
        logic [N-1:0]  rv;
        logic          re;
        logic [DW-1:0] rd;
        logic          psel_at_rsp;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [2:0]    p;
        logic          w;
        bit            unstable;
        bit            en_wo_sel;
        bit            timed_out;
    } obs_t;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_strb(req_strb), .req_prot(req_prot),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    // Completer: ready after cfg_waits low ACCESS cycles; -1 means never.
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) acc_cnt <= 0;
        else if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign PREADY  = PSEL && PENABLE && (cfg_waits >= 0) && (acc_cnt >= cfg_waits);
    assign PSLVERR = PREADY && cfg_err;
    assign PRDATA  = cfg_rdata;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input logic [2:0] p);
        m_w[i] = w; m_a[i] = a; m_d[i] = d; m_s[i] = s; m_p[i] = p;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW]  = s;
        req_prot[i*3 +: 3]    = p;
        req_valid[i]          = 1'b1;
    endtask

    task automatic apply_reset();
        PRESET = 1'b1;
        req_valid = '0;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        model_last = N - 1;
    endtask

    // Waits for a grant, drops the winner's valid, and records the transfer.
    task automatic run_xfer(output obs_t o);
        int g;
        o = '{default: 0};
        o.timed_out = 1;
        #1;
        for (int n = 0; n < 40; n++) begin
            if (req_ready != 0) begin
                o.timed_out = 0;
                break;
            end
            @(negedge PCLK);
        end
        if (o.timed_out) return;
        o.gnt = req_ready;
        o.gnt_psel = PSEL | PENABLE;
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        @(posedge PCLK);
        #1;
        req_valid[g] = 1'b0;
        o.timed_out = 1;
        for (int n = 0; n < 60; n++) begin
            @(negedge PCLK);
            o.total++;
            if (PENABLE && !PSEL) o.en_wo_sel = 1;
            if (PSEL && !PENABLE) begin
                o.setup++;
                o.a = PADDR; o.d = PWDATA; o.s = PSTRB; o.p = PPROT; o.w = PWRITE;
            end
            if (PSEL && PENABLE) begin
                o.access++;
                if (PADDR !== o.a || PWDATA !== o.d || PSTRB !== o.s ||
                    PPROT !== o.p || PWRITE !== o.w) o.unstable = 1;
            end
            if (rsp_valid != 0) begin
                o.rv = rsp_valid; o.re = rsp_err; o.rd = rsp_rdata;
                o.psel_at_rsp = PSEL;
                o.timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i * 16), $urandom, 4'hF, 3'd1);
        @(negedge PCLK);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, PWRITE,
             PADDR, PWDATA, PSTRB, PPROT} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b rsp=%b psel=%b paddr=%h exp all zero",
                     req_ready, rsp_valid, PSEL, PADDR);
        end
        req_valid = '0;
        PRESET = 1'b0;
        model_last = N - 1;
        @(negedge PCLK);
        checks++;
        if ({req_ready, rsp_valid, PSEL, PENABLE} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got ready=%b rsp=%b psel=%b exp 0",
                     req_ready, rsp_valid, PSEL);
        end
    endtask

    task automatic test_single_write();
        obs_t o;
        cfg_waits = 0; cfg_err = 0; cfg_rdata = 32'hA5A5_5A5A;
        set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'd2);
        run_xfer(o);
        checks++;
        if (o.timed_out) begin failures++; $display("FAIL single_done got timeout exp rsp"); end
        checks++;
        if (o.gnt !== 4'b0001 || o.gnt_psel) begin
            failures++; $display("FAIL single_gnt got=%b psel=%0d exp=0001 psel=0", o.gnt, o.gnt_psel);
        end
        checks++;
        if (o.setup != 1 || o.access != 1 || o.total != 3) begin
            failures++;
            $display("FAIL single_timing got setup=%0d access=%0d total=%0d exp 1 1 3",
                     o.setup, o.access, o.total);
        end
        checks++;
        if (o.a !== 32'h10 || o.d !== 32'hDEAD_BEEF || o.s !== 4'hF || o.w !== 1'b1 || o.p !== 3'd2) begin
            failures++;
            $display("FAIL single_bus got a=%h d=%h s=%h w=%b p=%0d exp 10 deadbeef f 1 2",
                     o.a, o.d, o.s, o.w, o.p);
        end
        checks++;
        if (o.rv !== 4'b0001 || o.re !== 1'b0 || o.rd !== '0 || o.psel_at_rsp !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp got rv=%b err=%b rd=%h exp 0001 0 0", o.rv, o.re, o.rd);
        end
        model_last = 0;
    endtask

    task automatic test_read_wait();
        obs_t o;
        cfg_waits = 2; cfg_err = 0; cfg_rdata = 32'h1234_5678;
        set_req(2, 1'b0, 32'h20, $urandom, 4'hF, 3'd5);
        run_xfer(o);
        checks++;
        if (o.timed_out || o.gnt !== 4'b0100) begin
            failures++; $display("FAIL read_gnt got=%b to=%0d exp=0100", o.gnt, o.timed_out);
        end
        checks++;
        if (o.access != 3 || o.unstable || o.en_wo_sel) begin
            failures++;
            $display("FAIL read_wait got access=%0d unstable=%0d exp 3 0", o.access, o.unstable);
        end
        checks++;
        if (o.a !== 32'h20 || o.d !== '0 || o.s !== '0 || o.w !== 1'b0 || o.p !== 3'd5) begin
            failures++;
            $display("FAIL read_bus got a=%h d=%h s=%h w=%b p=%0d exp 20 0 0 0 5",
                     o.a, o.d, o.s, o.w, o.p);
        end
        checks++;
        if (o.rv !== 4'b0100 || o.re !== 1'b0 || o.rd !== 32'h1234_5678) begin
            failures++;
            $display("FAIL read_rsp got rv=%b err=%b rd=%h exp 0100 0 12345678", o.rv, o.re, o.rd);
        end
        model_last = 2;
        cfg_waits = 0;
    endtask

    task automatic test_round_robin();
        obs_t o;
        int exp_g;
        int seq [6];
        logic [N-1:0] ev;
        apply_reset();
        cfg_waits = 0; cfg_err = 0; cfg_rdata = $urandom;
        for (int i = 0; i < N; i++) set_req(i, 1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom));
        for (int t = 0; t < 6; t++) begin
            if (t == 4) begin
                set_req(1, 1'b1, 32'h100, $urandom, 4'h3, 3'd0);
                set_req(3, 1'b1, 32'h300, $urandom, 4'hC, 3'd0);
            end
            exp_g = rr_pick(req_valid, model_last);
            seq[t] = exp_g;
            run_xfer(o);
            ev = N'(1) << exp_g;
            checks++;
            if (o.timed_out || o.gnt !== ev || o.rv !== ev) begin
                failures++;
                $display("FAIL rr_order[%0d] got gnt=%b rv=%b exp=%b", t, o.gnt, o.rv, ev);
            end
            model_last = exp_g;
        end
        checks++;
        if (seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3 || seq[4] != 1 || seq[5] != 3) begin
            failures++; $display("FAIL rr_model got %0d%0d%0d%0d%0d%0d exp 012313",
                                 seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]);
        end
    endtask

    task automatic test_slverr();
        obs_t o;
        logic [DW-1:0] rdv;
        cfg_waits = 1; cfg_err = 1; cfg_rdata = $urandom;
        set_req(1, 1'b1, 32'h44, $urandom, 4'hF, 3'd0);
        run_xfer(o);
        checks++;
        if (o.timed_out || o.rv !== 4'b0010 || o.re !== 1'b1 || o.rd !== '0 || o.access != 2) begin
            failures++;
            $display("FAIL slverr_rsp got rv=%b err=%b rd=%h acc=%0d exp 0010 1 0 2",
                     o.rv, o.re, o.rd, o.access);
        end
        model_last = 1;
        rdv = $urandom;
        cfg_waits = 0; cfg_err = 0; cfg_rdata = rdv;
        set_req(3, 1'b0, 32'h48, $urandom, 4'hF, 3'd0);
        run_xfer(o);
        checks++;
        if (o.timed_out || o.rv !== 4'b1000 || o.re !== 1'b0 || o.rd !== rdv) begin
            failures++;
            $display("FAIL slverr_next got rv=%b err=%b rd=%h exp 1000 0 %h", o.rv, o.re, o.rd, rdv);
        end
        model_last = 3;
    endtask

    task automatic test_timeout();
        obs_t o;
        int r;
        logic [N-1:0] ev;
        r = $urandom_range(0, N - 1);
        cfg_waits = -1; cfg_err = 0; cfg_rdata = 32'hFFFF_0000;
        set_req(r, 1'b0, $urandom, $urandom, 4'hF, 3'd0);
        ev = N'(1) << r;
        run_xfer(o);
        checks++;
        if (o.timed_out || o.access != TO || o.total != TO + 2) begin
            failures++;
            $display("FAIL timeout_cycles got access=%0d total=%0d exp %0d %0d",
                     o.access, o.total, TO, TO + 2);
        end
        checks++;
        if (o.rv !== ev || o.re !== 1'b1 || o.rd !== '0 || o.psel_at_rsp !== 1'b0) begin
            failures++;
            $display("FAIL timeout_rsp got rv=%b err=%b rd=%h psel=%b exp %b 1 0 0",
                     o.rv, o.re, o.rd, o.psel_at_rsp, ev);
        end
        model_last = r;
        cfg_waits = 0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int n;
        int seen;
        cfg_waits = -1; cfg_err = 0; cfg_rdata = $urandom;
        set_req(2, 1'b1, 32'h80, $urandom, 4'hF, 3'd7);
        n = 0;
        while (!(PSEL && PENABLE) && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        checks++;
        if (!(PSEL && PENABLE)) begin
            failures++; $display("FAIL rstmid_access got psel=%b pen=%b exp 1 1", PSEL, PENABLE);
        end
        set_req(1, 1'b1, 32'h90, $urandom, 4'hF, 3'd0);
        @(negedge PCLK);
        #2;
        PRESET = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, PWRITE,
             PADDR, PWDATA, PSTRB, PPROT} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got ready=%b psel=%b pen=%b paddr=%h exp all zero",
                     req_ready, PSEL, PENABLE, PADDR);
        end
        req_valid = '0;
        cfg_waits = 0;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        model_last = N - 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            if (rsp_valid != 0 || PSEL) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL rstmid_no_rsp got %0d active cycles exp 0", seen);
        end
        set_req(3, 1'b0, 32'h33, $urandom, 4'h0, 3'd0);
        set_req(0, 1'b1, 32'h11, $urandom, 4'hF, 3'd0);
        run_xfer(o);
        checks++;
        if (o.timed_out || o.gnt !== 4'b0001 || o.rv !== 4'b0001) begin
            failures++; $display("FAIL rstmid_first got gnt=%b rv=%b exp 0001", o.gnt, o.rv);
        end
        run_xfer(o);
        checks++;
        if (o.timed_out || o.gnt !== 4'b1000 || o.rv !== 4'b1000) begin
            failures++; $display("FAIL rstmid_second got gnt=%b rv=%b exp 1000", o.gnt, o.rv);
        end
        model_last = 3;
    endtask

    task automatic test_random();
        obs_t o;
        int g;
        int to;
        int age [N];
        logic [N-1:0] ev;
        logic [DW-1:0] exp_rd;
        logic exp_re;
        for (int i = 0; i < N; i++) age[i] = 0;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1))
                    set_req(i, 1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom));
            end
            if (req_valid == 0) begin
                g = $urandom_range(0, N - 1);
                set_req(g, 1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom));
            end
            to = ($urandom_range(0, 9) == 0);
            cfg_waits = to ? -1 : $urandom_range(0, 3);
            cfg_err = ($urandom_range(0, 3) == 0);
            cfg_rdata = $urandom;
            g = rr_pick(req_valid, model_last);
            ev = N'(1) << g;
            exp_re = to ? 1'b1 : cfg_err;
            exp_rd = (!m_w[g] && !exp_re) ? cfg_rdata : '0;
            for (int i = 0; i < N; i++) if (req_valid[i] && i != g) age[i]++;
            run_xfer(o);
            checks++;
            if (o.timed_out || o.gnt !== ev || o.gnt_psel) begin
                failures++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", it, o.gnt, ev);
            end
            checks++;
            if (o.access != (to ? TO : cfg_waits + 1) || o.setup != 1 || o.unstable || o.en_wo_sel) begin
                failures++;
                $display("FAIL rand_timing[%0d] got setup=%0d access=%0d unstable=%0d exp 1 %0d 0",
                         it, o.setup, o.access, o.unstable, to ? TO : cfg_waits + 1);
            end
            checks++;
            if (o.a !== m_a[g] || o.w !== m_w[g] || o.p !== m_p[g] ||
                o.d !== (m_w[g] ? m_d[g] : '0) || o.s !== (m_w[g] ? m_s[g] : '0)) begin
                failures++;
                $display("FAIL rand_bus[%0d] got a=%h w=%b d=%h s=%h exp a=%h w=%b",
                         it, o.a, o.w, o.d, o.s, m_a[g], m_w[g]);
            end
            checks++;
            if (o.rv !== ev || o.re !== exp_re || o.rd !== exp_rd) begin
                failures++;
                $display("FAIL rand_rsp[%0d] got rv=%b err=%b rd=%h exp %b %b %h",
                         it, o.rv, o.re, o.rd, ev, exp_re, exp_rd);
            end
            checks++;
            if (age[g] > N - 1) begin
                failures++; $display("FAIL rand_fair[%0d] got wait=%0d exp <=%0d", it, age[g], N - 1);
            end
            age[g] = 0;
            model_last = g;
        end
        cfg_waits = 0;
    endtask

    initial begin
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        @(negedge PCLK);
        test_reset();
        test_single_write();
        test_read_wait();
        test_round_robin();
        test_slverr();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB master port between NUM_REQ local requesters, such as the sequencer-side driver, a register-model adapter and a DMA stub. Each requester presents a command with a valid/ready handshake. The block picks one by round-robin, runs a complete APB3/APB4 SETUP→ACCESS transfer that honours PREADY wait states, and returns a one-cycle response to the winner. It sits between the requesters and the APB bus signals that the master driver normally owns.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 32: PADDR width.
- DATA_W, 32: PWDATA/PRDATA width. PSTRB width is DATA_W/8.
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before the block aborts. A value of 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_strb  in  NUM_REQ*DATA_W/8  packed byte strobes.
- req_prot  in  NUM_REQ*3  packed PPROT values.
- req_ready  out  NUM_REQ  one-hot grant; the command is captured at the edge where valid and ready are both high.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers.
- rsp_err  out  1  PSLVERR or timeout; valid with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB byte strobes.
- PPROT  out  3  APB protection.
- PREADY, PSLVERR  in  1  APB completer response.
- PRDATA  in  DATA_W  APB read data.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS.
- In IDLE, the block grants when any req_valid is high. The winner is the first requester with valid set, searching from last_grant+1 and wrapping modulo NUM_REQ.
  - req_ready[winner] is combinational and asserted in that cycle only.
  - The command is latched into internal registers and last_grant is updated to the winner.
  - Next state is SETUP.
- In SETUP, PSEL=1 and PENABLE=0, with PADDR/PWRITE/PWDATA/PSTRB/PPROT taken from the latched command. Next state is always ACCESS.
- In ACCESS, PSEL=1 and PENABLE=1, and all address/control/data signals are held stable.
  - On PREADY=1: the transfer completes and the next state is IDLE.
  - On PREADY=0: the wait counter increments.
  - On TIMEOUT≠0 with the counter equal to TIMEOUT-1 and PREADY=0: the transfer aborts and the next state is IDLE.
- Completion is registered. In the cycle after the completing edge:
  - rsp_valid[owner]=1.
  - rsp_err is PSLVERR, or 1 on abort.
  - rsp_rdata is PRDATA for a read that ended without error or abort, else 0.
- Read transfers drive PSTRB=0 and PWDATA=0.
- Outside SETUP/ACCESS: PSEL=0, PENABLE=0, and PADDR/PWRITE/PWDATA/PSTRB/PPROT return to 0.
- A requester must hold its command stable from asserting valid until it sees ready. Deasserting valid before the grant withdraws the request and is legal.
- A requester may reassert valid in the rsp_valid cycle. The arbiter evaluates requests in that cycle, because the FSM is already in IDLE.
- Reset, including mid-transfer: every output goes to 0 immediately; last_grant = NUM_REQ-1, so requester 0 has first priority; the wait counter is cleared and the state is IDLE. No response is issued for the killed transfer.

## Timing
- With zero wait states: grant at T0, SETUP at T1, ACCESS at T2 (PREADY=1), rsp_valid at T3. The next grant is possible at T3 and its SETUP at T4.
- Each wait state adds one ACCESS cycle.
- On timeout, PSEL/PENABLE drop at the edge following the TIMEOUT-th low-PREADY cycle, and rsp_valid follows in that same cycle.
- PSEL and PENABLE never assert in the same cycle as req_ready.
- PENABLE is never 1 while PSEL is 0.
- Grant fairness: a continuously requesting requester is served within NUM_REQ transfers.

## Test plan
- Single transfer: requester 0 writes addr 0x10, data 0xDEADBEEF, strb 0xF; PREADY tied high.
  - Required: PSEL at T1, PENABLE at T2, rsp_valid=4'b0001 at T3, rsp_err=0, rsp_rdata=0.
- Read with wait states: requester 2 reads addr 0x20; PREADY low for 2 ACCESS cycles; PRDATA=0x1234_5678.
  - Required: 3 ACCESS cycles, then rsp_valid=4'b0100 and rsp_rdata=0x12345678.
- Round-robin out of reset: all four requesters hold valid out of reset.
  - Required: grant order 0,1,2,3.
  - Then requesters 1 and 3 re-request; required order 1, then 3.
- Completer error: write with PSLVERR=1 at completion.
  - Required: rsp_err=1 alongside rsp_valid; the next grant proceeds normally.
- Timeout: TIMEOUT=16 with PREADY held low.
  - Required: exactly 16 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_rdata=0.
- Reset mid-transfer: assert PRESET during ACCESS.
  - Required: all outputs are 0 in the same cycle and no rsp_valid is issued.
  - After release, simultaneous requests from 0 and 3 grant 0 first.
